// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
// The master drives requests and write data; the slave (the FIFO) drives data and status.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 20,
  parameter int PTR_WIDTH  = 3
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status, sticky error flags and selectable
// registered-read or first-word-fall-through output.
module sync_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 20,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam int CW = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr_r, rd_ptr_r, count_r;
  logic [PTR_WIDTH:0]    wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
  logic [PTR_WIDTH-1:0]  wr_addr_s, rd_addr_s;
  logic                  wr_ok_s, rd_ok_s, full_nxt_s, empty_nxt_s;
  logic                  full_r, empty_r, af_r, ae_r, ovf_r, udf_r;

  assign wr_addr_s = wr_ptr_r[PTR_WIDTH-1:0];
  assign rd_addr_s = rd_ptr_r[PTR_WIDTH-1:0];

  // Accepted requests and the post-edge pointer/status they produce
  always_comb begin
    wr_ok_s      = bus.w_en & ~full_r;
    rd_ok_s      = bus.r_en & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r + {{PTR_WIDTH{1'b0}}, wr_ok_s};
    rd_ptr_nxt_s = rd_ptr_r + {{PTR_WIDTH{1'b0}}, rd_ok_s};
    count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s   = (wr_ptr_nxt_s[PTR_WIDTH] != rd_ptr_nxt_s[PTR_WIDTH]) &&
                   (wr_ptr_nxt_s[PTR_WIDTH-1:0] == rd_ptr_nxt_s[PTR_WIDTH-1:0]);
  end

  // Pointers, occupancy and flags; error flags are sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {CW{1'b0}};
      rd_ptr_r <= {CW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
      af_r     <= (count_nxt_s >= CW'(AF_LEVEL));
      ae_r     <= (count_nxt_s <= CW'(AE_LEVEL));
      ovf_r    <= ovf_r | (bus.w_en & full_r);
      udf_r    <= udf_r | (bus.r_en & empty_r);
    end
  end

  // Storage array; deliberately not reset, every entry is written before it is read
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_addr_s] <= bus.data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem_r[rd_addr_s];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_r;

      // Head word captured on the edge that accepts a read, held otherwise
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_ok_s) begin
          dout_r <= mem_r[rd_addr_s];
        end
      end

      assign bus.data_out = dout_r;
    end
  endgenerate

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read instance and a fall-through instance
// share clock and reset; every expected value below is hand-derived.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  sync_fifo_if #(.DATA_WIDTH(20), .PTR_WIDTH(3)) bus0 ();
  sync_fifo_if #(.DATA_WIDTH(20), .PTR_WIDTH(3)) bus1 ();

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(20), .PTR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sync_fifo #(.DEPTH(8), .DATA_WIDTH(20), .PTR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // One clock on the registered-read FIFO; outputs are then sampled 1 time unit after the edge
  task automatic step0(input logic we, input logic [19:0] d, input logic re);
    bus0.w_en = we; bus0.data_in = d; bus0.r_en = re;
    @(posedge clk); #1;
    bus0.w_en = 1'b0; bus0.r_en = 1'b0;
  endtask

  task automatic step1(input logic we, input logic [19:0] d, input logic re);
    bus1.w_en = we; bus1.data_in = d; bus1.r_en = re;
    @(posedge clk); #1;
    bus1.w_en = 1'b0; bus1.r_en = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.w_en = 1'b0; bus0.r_en = 1'b0; bus0.data_in = 20'h0;
    bus1.w_en = 1'b0; bus1.r_en = 1'b0; bus1.data_in = 20'h0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (bus0.count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d exp 0", bus0.count); end
    tests_run++; if (bus0.empty !== 1'b1 || bus0.full !== 1'b0) begin tests_failed++; $display("FAIL reset_empty_full: got e=%b f=%b exp e=1 f=0", bus0.empty, bus0.full); end
    tests_run++; if (bus0.almost_empty !== 1'b1 || bus0.almost_full !== 1'b0) begin tests_failed++; $display("FAIL reset_almost: got ae=%b af=%b exp ae=1 af=0", bus0.almost_empty, bus0.almost_full); end
    tests_run++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_sticky: got ovf=%b udf=%b exp 0 0", bus0.overflow, bus0.underflow); end
    tests_run++; if (bus0.data_out !== 20'h0) begin tests_failed++; $display("FAIL reset_dout: got %h exp 00000", bus0.data_out); end
    tests_run++; if (bus1.empty !== 1'b1 || bus1.count !== 4'd0) begin tests_failed++; $display("FAIL reset_fwft: got e=%b c=%0d exp e=1 c=0", bus1.empty, bus1.count); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    step0(1'b1, 20'h00011, 1'b0);
    step0(1'b1, 20'h00022, 1'b0);
    step0(1'b1, 20'h00033, 1'b0);
    step0(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus0.data_out !== 20'h00011 || bus0.count !== 4'd2) begin tests_failed++; $display("FAIL mid_pre: got d=%h c=%0d exp d=00011 c=2", bus0.data_out, bus0.count); end
    #2 rst = 1'b1;
    #2;
    tests_run++; if (bus0.count !== 4'd0 || bus0.empty !== 1'b1) begin tests_failed++; $display("FAIL mid_async: got c=%0d e=%b exp c=0 e=1", bus0.count, bus0.empty); end
    tests_run++; if (bus0.data_out !== 20'h0) begin tests_failed++; $display("FAIL mid_dout: got %h exp 00000", bus0.data_out); end
    rst = 1'b0;
    step0(1'b1, 20'h00055, 1'b0);
    step0(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus0.data_out !== 20'h00055 || bus0.empty !== 1'b1) begin tests_failed++; $display("FAIL mid_first_word: got d=%h e=%b exp d=00055 e=1", bus0.data_out, bus0.empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      step0(1'b1, 20'(i), 1'b0);
      tests_run++; if (bus0.count !== 4'(i)) begin tests_failed++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, bus0.count, i); end
      tests_run++; if (bus0.almost_full !== (i >= 6) || bus0.full !== (i == 8)) begin tests_failed++; $display("FAIL fill_flags[%0d]: got af=%b f=%b exp af=%b f=%b", i, bus0.almost_full, bus0.full, (i >= 6), (i == 8)); end
      tests_run++; if (bus0.almost_empty !== (i <= 2) || bus0.empty !== 1'b0) begin tests_failed++; $display("FAIL fill_ae[%0d]: got ae=%b e=%b exp ae=%b e=0", i, bus0.almost_empty, bus0.empty, (i <= 2)); end
    end
    tests_run++; if (bus0.overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_before: got %b exp 0", bus0.overflow); end
    step0(1'b1, 20'h00099, 1'b0);
    tests_run++; if (bus0.overflow !== 1'b1 || bus0.count !== 4'd8 || bus0.full !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got ovf=%b c=%0d f=%b exp 1 8 1", bus0.overflow, bus0.count, bus0.full); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      step0(1'b0, 20'h0, 1'b1);
      tests_run++; if (bus0.data_out !== 20'(i)) begin tests_failed++; $display("FAIL drain_data[%0d]: got %h exp %h", i, bus0.data_out, 20'(i)); end
      tests_run++; if (bus0.count !== 4'(8 - i) || bus0.almost_empty !== ((8 - i) <= 2)) begin tests_failed++; $display("FAIL drain_count[%0d]: got c=%0d ae=%b exp c=%0d ae=%b", i, bus0.count, bus0.almost_empty, 8 - i, ((8 - i) <= 2)); end
    end
    tests_run++; if (bus0.empty !== 1'b1 || bus0.almost_empty !== 1'b1 || bus0.full !== 1'b0) begin tests_failed++; $display("FAIL drain_end: got e=%b ae=%b f=%b exp 1 1 0", bus0.empty, bus0.almost_empty, bus0.full); end
    step0(1'b0, 20'h0, 1'b0);
    tests_run++; if (bus0.data_out !== 20'h00008 || bus0.overflow !== 1'b1) begin tests_failed++; $display("FAIL hold_idle: got d=%h ovf=%b exp d=00008 ovf=1", bus0.data_out, bus0.overflow); end
  endtask

  task automatic test_underflow();
    tests_run++; if (bus0.underflow !== 1'b0) begin tests_failed++; $display("FAIL udf_before: got %b exp 0", bus0.underflow); end
    step0(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus0.underflow !== 1'b1 || bus0.count !== 4'd0 || bus0.empty !== 1'b1) begin tests_failed++; $display("FAIL udf_set: got udf=%b c=%0d e=%b exp 1 0 1", bus0.underflow, bus0.count, bus0.empty); end
    tests_run++; if (bus0.data_out !== 20'h00008) begin tests_failed++; $display("FAIL udf_dout: got %h exp 00008", bus0.data_out); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step0(1'b1, 20'h00100 + 20'(i), 1'b0);
    tests_run++; if (bus0.count !== 4'd4) begin tests_failed++; $display("FAIL b2b_prefill: got %0d exp 4", bus0.count); end
    for (int k = 0; k < 20; k++) begin
      step0(1'b1, 20'h00104 + 20'(k), 1'b1);
      tests_run++; if (bus0.data_out !== 20'h00100 + 20'(k) || bus0.count !== 4'd4) begin tests_failed++; $display("FAIL b2b[%0d]: got d=%h c=%0d exp d=%h c=4", k, bus0.data_out, bus0.count, 20'h00100 + 20'(k)); end
    end
    for (int k = 0; k < 4; k++) begin
      step0(1'b0, 20'h0, 1'b1);
      tests_run++; if (bus0.data_out !== 20'h00114 + 20'(k)) begin tests_failed++; $display("FAIL b2b_drain[%0d]: got %h exp %h", k, bus0.data_out, 20'h00114 + 20'(k)); end
    end
    tests_run++; if (bus0.empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty: got %b exp 1", bus0.empty); end
  endtask

  task automatic test_full_simul();
    pulse_reset();
    tests_run++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin tests_failed++; $display("FAIL sticky_clear: got ovf=%b udf=%b exp 0 0", bus0.overflow, bus0.underflow); end
    for (int i = 0; i < 8; i++) step0(1'b1, 20'h00200 + 20'(i), 1'b0);
    tests_run++; if (bus0.full !== 1'b1) begin tests_failed++; $display("FAIL fs_full: got %b exp 1", bus0.full); end
    step0(1'b1, 20'h002FF, 1'b1);
    tests_run++; if (bus0.data_out !== 20'h00200 || bus0.count !== 4'd7) begin tests_failed++; $display("FAIL fs_read: got d=%h c=%0d exp d=00200 c=7", bus0.data_out, bus0.count); end
    tests_run++; if (bus0.overflow !== 1'b1 || bus0.full !== 1'b0) begin tests_failed++; $display("FAIL fs_flags: got ovf=%b f=%b exp 1 0", bus0.overflow, bus0.full); end
    for (int i = 1; i < 8; i++) begin
      step0(1'b0, 20'h0, 1'b1);
      tests_run++; if (bus0.data_out !== 20'h00200 + 20'(i)) begin tests_failed++; $display("FAIL fs_drain[%0d]: got %h exp %h", i, bus0.data_out, 20'h00200 + 20'(i)); end
    end
    step0(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus0.data_out !== 20'h00207 || bus0.empty !== 1'b1) begin tests_failed++; $display("FAIL fs_dropped: got d=%h e=%b exp d=00207 e=1", bus0.data_out, bus0.empty); end
  endtask

  task automatic test_empty_simul();
    pulse_reset();
    step0(1'b1, 20'h00300, 1'b1);
    tests_run++; if (bus0.count !== 4'd1 || bus0.empty !== 1'b0 || bus0.underflow !== 1'b1) begin tests_failed++; $display("FAIL es_flags: got c=%0d e=%b udf=%b exp 1 0 1", bus0.count, bus0.empty, bus0.underflow); end
    tests_run++; if (bus0.data_out !== 20'h0) begin tests_failed++; $display("FAIL es_dout: got %h exp 00000", bus0.data_out); end
    step0(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus0.data_out !== 20'h00300 || bus0.empty !== 1'b1) begin tests_failed++; $display("FAIL es_read: got d=%h e=%b exp d=00300 e=1", bus0.data_out, bus0.empty); end
  endtask

  task automatic test_fwft();
    step1(1'b1, 20'hABCDE, 1'b0);
    tests_run++; if (bus1.empty !== 1'b0 || bus1.data_out !== 20'hABCDE) begin tests_failed++; $display("FAIL fwft_first: got e=%b d=%h exp e=0 d=abcde", bus1.empty, bus1.data_out); end
    step1(1'b0, 20'h0, 1'b0);
    tests_run++; if (bus1.data_out !== 20'hABCDE || bus1.count !== 4'd1) begin tests_failed++; $display("FAIL fwft_hold: got d=%h c=%0d exp d=abcde c=1", bus1.data_out, bus1.count); end
    step1(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus1.empty !== 1'b1 || bus1.count !== 4'd0) begin tests_failed++; $display("FAIL fwft_pop: got e=%b c=%0d exp e=1 c=0", bus1.empty, bus1.count); end
    step1(1'b1, 20'h11111, 1'b0);
    step1(1'b1, 20'h22222, 1'b0);
    tests_run++; if (bus1.data_out !== 20'h11111) begin tests_failed++; $display("FAIL fwft_head: got %h exp 11111", bus1.data_out); end
    step1(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus1.data_out !== 20'h22222 || bus1.count !== 4'd1) begin tests_failed++; $display("FAIL fwft_next: got d=%h c=%0d exp d=22222 c=1", bus1.data_out, bus1.count); end
    step1(1'b0, 20'h0, 1'b1);
    tests_run++; if (bus1.empty !== 1'b1) begin tests_failed++; $display("FAIL fwft_empty: got %b exp 1", bus1.empty); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fill_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_full_simul();
    test_empty_simul();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001: The block SHALL have parameter DEPTH, default 8, giving the number of storage entries; DEPTH SHALL equal 2**PTR_WIDTH.
REQ-002: The block SHALL have parameter DATA_WIDTH, default 20, giving the word width in bits.
REQ-003: The block SHALL have parameter PTR_WIDTH, default 3, giving the address width in bits.
REQ-004: The block SHALL have parameter AF_LEVEL, default 6, giving the almost-full threshold in entries.
REQ-005: The block SHALL have parameter AE_LEVEL, default 2, giving the almost-empty threshold in entries; the block SHALL require 1 <= AE_LEVEL < AF_LEVEL <= DEPTH.
REQ-006: The block SHALL have parameter FWFT, default 0, selecting the read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-007: The block SHALL have one clock and an asynchronous, active-high reset; all ports are listed in REQ-008 to REQ-020.
REQ-008: clk  input  1  single clock; all state changes on its rising edge.
REQ-009: rst  input  1  asynchronous, active-high reset.
REQ-010: w_en  input  1  write request.
REQ-011: data_in  input  DATA_WIDTH  write data.
REQ-012: r_en  input  1  read request.
REQ-013: data_out  output  DATA_WIDTH  read data.
REQ-014: full  output  1  asserted when count == DEPTH.
REQ-015: empty  output  1  asserted when count == 0.
REQ-016: almost_full  output  1  asserted when count >= AF_LEVEL.
REQ-017: almost_empty  output  1  asserted when count <= AE_LEVEL.
REQ-018: count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-019: overflow  output  1  sticky flag for a write attempted while full.
REQ-020: underflow  output  1  sticky flag for a read attempted while empty.

Function
REQ-021: Write and read pointers SHALL be PTR_WIDTH+1-bit binary counters; the low PTR_WIDTH bits SHALL address memory, and each pointer SHALL wrap modulo 2**(PTR_WIDTH+1).
REQ-022: A write SHALL be accepted on an edge where w_en & !full: data_in is stored at the write address and the write pointer increments.
REQ-023: A read SHALL be accepted on an edge where r_en & !empty, and the read pointer SHALL increment.
REQ-024: full, empty, almost_full, almost_empty and count SHALL be registered and reflect the state after the edge; full/empty SHALL derive from pointer equality with MSB differing/equal.
REQ-025: On a simultaneous accepted read and write, count SHALL be unchanged and both pointers SHALL advance.
REQ-026: When w_en & r_en occur while full, the read SHALL be accepted, the write SHALL be dropped, overflow SHALL set, and count SHALL decrement by 1.
REQ-027: When w_en & r_en occur while empty, the write SHALL be accepted, the read SHALL be rejected, underflow SHALL set, and count SHALL become 1.
REQ-028: A rejected write SHALL not modify memory or the write pointer; a rejected read SHALL not modify data_out or the read pointer.
REQ-029: overflow/underflow SHALL set on the edge of the offending request and SHALL clear only on reset.
REQ-030: With FWFT=0, data_out SHALL update to the head entry on the edge accepting the read (1-cycle latency) and SHALL hold otherwise.
REQ-031: With FWFT=1, data_out SHALL continuously present the entry at the read address, valid whenever empty=0; the first write into an empty FIFO SHALL be visible on data_out the cycle after its edge, with no r_en.
REQ-032: Memory contents SHALL not be reset; entries are write-before-read only.

Reset
REQ-033: While rst=1, independent of clk, the block SHALL force both pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, and, for FWFT=0, data_out=0.
REQ-034: Reset asserted mid-operation SHALL discard all contents; the first accepted write after release SHALL be the first word read.

Verification (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, DATA_WIDTH=20)
REQ-035: The bench SHALL cover: after 3 writes, assert rst between edges -> count=0, empty=1, data_out=0 immediately; write 0x00055 after release -> first read returns 0x00055.
REQ-036: The bench SHALL cover: 8 writes 0x00001..0x00008 (FWFT=0) -> almost_full at count 6, full after the 8th; 9th write -> overflow=1, count=8; 8 reads -> data_out 0x00001..0x00008, each one cycle after its read edge; then empty=1 and almost_empty=1.
REQ-037: The bench SHALL cover: r_en on empty -> underflow=1, count=0, data_out unchanged.
REQ-038: The bench SHALL cover: at count=4, w_en & r_en for 20 cycles with incrementing data -> count stays 4, pointers wrap, output order matches input order.
REQ-039: The bench SHALL cover: at full, w_en & r_en on the same edge -> read returns the oldest word, overflow=1, count=7, dropped word never read.
REQ-040: The bench SHALL cover: FWFT=1, write 0xABCDE into empty -> next cycle empty=0, data_out=0xABCDE with r_en low; one r_en -> empty=1.
